// File: rtl/log_fx.sv
// log_fx: two-stage pipelined Mitchell log2 (place + F_BW fraction bits) with ready/valid.
// Optional LOG_FX_ROUND_EN rounds the fraction half-up, saturating without carry into place.
module log_fx #(
  parameter int I_BW = 32,
  parameter int F_BW = 2,
  parameter int O_BW = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic [I_BW-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic            ready_o,
  output logic [O_BW-1:0] data_o,
  output logic            valid_o,
  output logic            last_o,
  input  logic            ready_i
);
  localparam int P_BW = $clog2(I_BW + 1);
  localparam logic [O_BW-1:0] F_MASK = O_BW'((1 << F_BW) - 1);
  logic            stall, cap;
  logic [P_BW-1:0] p_enc, s1_p, place;
  logic [I_BW-1:0] s1_data, tmp;
  logic            s1_valid, s1_last;
  logic [O_BW-1:0] frac, res;
  assign stall   = valid_o & ~ready_i;
  assign ready_o = ~stall;
  assign cap     = valid_i & en_i;
  always_comb begin
    p_enc = '0;
    for (int i = 0; i < I_BW; i++) p_enc = data_i[i] ? P_BW'(i) : p_enc;
  end
  // shifting by I_BW-p drops the leading one, leaving the fraction at the MSBs
  assign tmp   = s1_data << (P_BW'(I_BW) - s1_p);
  assign place = |s1_data ? s1_p + P_BW'(1) : '0;
  assign frac  = O_BW'(tmp >> (I_BW - F_BW));
`ifdef LOG_FX_ROUND_EN
  logic r;
  assign r   = tmp[I_BW-1-F_BW];
  assign res = (O_BW'(place) << F_BW) | ((r && frac != F_MASK) ? frac + O_BW'(1) : frac);
`else
  assign res = (O_BW'(place) << F_BW) | frac;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
      s1_data  <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      data_o   <= '0;
    end else if (!stall) begin
      s1_valid <= cap;
      s1_last  <= cap & last_i;
      s1_p     <= p_enc;
      s1_data  <= data_i;
      valid_o  <= s1_valid;
      last_o   <= s1_valid & s1_last;
      data_o   <= res;
    end
  end
endmodule

// File: tb/tb_log_fx.sv
// tb_log_fx: directed self-checking bench for log_fx at default parameters.
module tb_log_fx;
  logic        clk_i = 1'b0;
  logic        rst_n_i, en_i, valid_i, last_i, ready_i;
  logic [31:0] data_i;
  logic        ready_o, valid_o, last_o;
  logic [7:0]  data_o;
  int checks = 0;
  int errors = 0;

  log_fx dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i),
    .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o), .data_o(data_o),
    .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; en_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0; data_i = '0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || last_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h last=%b ready=%b, want 0 00 0 1", valid_o, data_o, last_o, ready_o);
    end
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [31:0] d, input logic [7:0] exp, input string nm);
    data_i = d; valid_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; last_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", nm, ready_o);
    end
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s early: valid_o=%b want 0", nm, valid_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o !== exp) begin
      errors++;
      $display("FAIL %s: valid=%b data=%h want 1 %h", nm, valid_o, data_o, exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_bp [8] = '{8'h04, 8'h08, 8'h0A, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    int ii = 0, oi = 0;
    logic prev_stall = 1'b0;
    logic [7:0] held = '0;
    for (int c = 0; c < 40 && oi < 8; c++) begin
      valid_i = (ii < 8); data_i = 32'(ii + 1); en_i = 1'b1; last_i = 1'b0;
      ready_i = !(c >= 4 && c <= 6);
      #1;
      checks++;
      if (ready_o !== !(valid_o && !ready_i)) begin
        errors++;
        $display("FAIL bp ready c=%0d: got %b valid_o=%b ready_i=%b", c, ready_o, valid_o, ready_i);
      end
      if (prev_stall) begin
        checks++;
        if (data_o !== held) begin
          errors++;
          $display("FAIL bp stable c=%0d: got %h want %h", c, data_o, held);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (data_o !== exp_bp[oi]) begin
          errors++;
          $display("FAIL bp data #%0d: got %h want %h", oi, data_o, exp_bp[oi]);
        end
        oi++;
      end
      prev_stall = valid_o && !ready_i;
      held = data_o;
      if (valid_i && ready_o) ii++;
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    checks++;
    if (oi != 8 || ii != 8) begin
      errors++;
      $display("FAIL bp count: out=%0d in=%0d want 8 8", oi, ii);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL bp extra: valid_o=%b want 0", valid_o);
      end
      tick();
    end
  endtask

  task automatic test_en_gating();
    logic [3:0]  en_pat = 4'b0101;
    logic [31:0] vals [4] = '{32'h1, 32'h2, 32'h4, 32'h8};
    logic [7:0]  got [2] = '{8'h00, 8'h00};
    int n = 0;
    logic last_seen = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      valid_i = (c < 4); en_i = (c < 4) ? en_pat[c] : 1'b0;
      data_i = (c < 4) ? vals[c] : '0; last_i = (c == 3);
      #1;
      if (valid_o) begin
        if (n < 2) got[n] = data_o;
        n++;
      end
      last_seen |= last_o;
      tick();
    end
    valid_i = 1'b0; last_i = 1'b0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL en count: got %0d want 2", n);
    end
    checks++;
    if (got[0] !== 8'h04 || got[1] !== 8'h0C) begin
      errors++;
      $display("FAIL en data: got %h %h want 04 0c", got[0], got[1]);
    end
    checks++;
    if (last_seen !== 1'b0) begin
      errors++;
      $display("FAIL en last: last_o seen=%b want 0", last_seen);
    end
  endtask

  task automatic test_frame_last();
    logic [7:0] exp_fr [3] = '{8'h04, 8'h08, 8'h0A};
    int ii = 0, oi = 0, stalls = 0;
    for (int c = 0; c < 30 && oi < 3; c++) begin
      valid_i = (ii < 3); data_i = 32'(ii + 1); last_i = (ii == 2); en_i = 1'b1;
      ready_i = !(valid_o && oi == 2 && stalls < 2);
      #1;
      if (valid_o) begin
        checks++;
        if (last_o !== (oi == 2) || data_o !== exp_fr[oi]) begin
          errors++;
          $display("FAIL frame #%0d: last=%b data=%h want %b %h", oi, last_o, data_o, oi == 2, exp_fr[oi]);
        end
      end
      if (valid_o && !ready_i) stalls++;
      if (valid_o && ready_i) oi++;
      if (valid_i && ready_o) ii++;
      tick();
    end
    valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    checks++;
    if (oi != 3 || stalls != 2) begin
      errors++;
      $display("FAIL frame count: out=%0d stalls=%0d want 3 2", oi, stalls);
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; en_i = 1'b1; valid_i = 1'b1; last_i = 1'b1; data_i = 32'h1;
    tick();
    data_i = 32'h2;
    tick();
    valid_i = 1'b0; last_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst setup: valid=%b ready=%b want 1 0", valid_o, ready_o);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || last_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst mid: valid=%b data=%h last=%b ready=%b want 0 00 0 1", valid_o, data_o, last_o, ready_o);
    end
    tick();
    rst_n_i = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst stale: valid_o=%b want 0", valid_o);
      end
    end
    test_single(32'h6, 8'h0E, "post_rst");
  endtask

  initial begin
    test_reset();
    test_single(32'h0, 8'h00, "zero");
    test_single(32'h1, 8'h04, "one");
    test_single(32'h6, 8'h0E, "six");
    test_single(32'h8000_0000, 8'h80, "msb");
    test_single(32'hFFFF_FFFF, 8'h83, "ones");
`ifdef LOG_FX_ROUND_EN
    test_single(32'hB, 8'h12, "round_b");
`else
    test_single(32'hB, 8'h11, "round_b");
`endif
    test_backpressure();
    test_en_gating();
    test_frame_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
